flappy_game_ctrl: RTL and testbench
===================================

Name: flappy_game_ctrl

Overview:
- Top-level game sequencer for the Flappy Bird design; runs on the same 10 Hz game tick as the bird-position datapath.
- Decides when the bird may move, and in which direction: player flap or gravity fall.
- Freezes the datapath on collision, runs a fixed death delay, and holds the game-over condition.
- Keeps the 2-digit BCD score and issues the restart/clear pulse that recentres the bird.

Parameters:
- GRAV_DIV, 2: gravity issues one down-move every GRAV_DIV ticks while no flap is held; legal range 1..15.
- DIE_TICKS, 20: number of ticks spent in DYING before OVER; legal range 1..255.
- SCORE_MAX, 99: score saturation value; must be ≤ 99.

Ports:
- clk10  in  1  game tick clock; all state changes on its rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  player start/restart button level, already synchronised to clk10.
- flap  in  1  player flap button level, already synchronised.
- collide  in  1  level from pipe/boundary collision logic.
- pipe_passed  in  1  one-tick pulse when the bird clears a pipe pair.
- bird_up  out  1  registered; the bird datapath moves up this tick.
- bird_down  out  1  registered; the bird datapath moves down this tick.
- bird_clr  out  1  registered one-tick pulse; the bird datapath recentres.
- game_end  out  1  registered; high in DYING and OVER.
- state  out  2  current state encoding.
- score_tens  out  4  BCD tens digit.
- score_ones  out  4  BCD ones digit.

Behaviour:
- Reset (clr_n low, asynchronous): the following apply immediately.
  - state = READY.
  - All 1-bit outputs are 0.
  - Score = 00.
  - Gravity counter = 0; death counter = 0; start_q = 0.
- Start edge detection:
  - start_q is a registered copy of start.
  - start_rise = start & ~start_q.
  - A held button does not retrigger the FSM.
- READY (00): bird_up and bird_down are 0; game_end is 0.
  - On start_rise: go to PLAYING, clear the score to 00, clear the gravity counter.
- PLAYING (01):
  - Collision has priority. If collide = 1 this tick: go to DYING, set game_end = 1 on the next edge, force bird_up = bird_down = 0, and ignore pipe_passed this tick.
  - Otherwise, if flap = 1: bird_up = 1, bird_down = 0, and the gravity counter resets to 0.
  - Otherwise, the gravity counter increments. When it reaches GRAV_DIV-1, bird_down = 1 for that tick and the counter wraps to 0; on all other ticks bird_down = 0.
  - Score: if pipe_passed = 1 and there is no collision, increment the BCD score.
    - Ones digit 9 wraps to 0 and carries into tens.
    - At SCORE_MAX the score holds (saturates); it never wraps to 00.
  - start is ignored.
- DYING (10):
  - game_end = 1; moves are 0.
  - The death counter counts 0..DIE_TICKS-1, then the FSM goes to OVER.
  - start, flap, collide and pipe_passed are ignored.
- OVER (11):
  - game_end = 1; the score holds.
  - On start_rise: bird_clr = 1 for exactly one tick, go to READY, clear the death counter.
  - The score is retained until the next READY→PLAYING transition.
- Output timing:
  - All outputs are registered; each reflects decisions made on the previous edge (1-tick latency from an input to its output).
  - bird_up and bird_down are never high together.
- Reset mid-operation: returns to READY from any state. bird_clr is not pulsed; the datapath is expected to share the board reset.
- Widths:
  - Gravity counter: 4 bits.
  - Death counter: 8 bits.
  - Score: two 4-bit BCD digits. Values A–F are unreachable, and an assertion must flag them.

Decomposition:
- Shared package flappy_pkg holds:
  - the state encodings READY/PLAYING/DYING/OVER (2 bits);
  - the BCD digit type;
  - the default constants GRAV_DIV, DIE_TICKS, SCORE_MAX.
- One sub-module: bcd_score_counter. Its interface is clk10, clr_n, clear, inc, and max value; it outputs tens and ones with saturation.
- The FSM and the gravity/death counters stay in the top level.

Test Plan:
- Reset, then a start pulse → state 01 after 1 edge; score 00; with flap = 0 and GRAV_DIV = 2, bird_down toggles 0,1,0,1.
- In PLAYING, hold flap for 3 ticks → bird_up = 1 for 3 ticks, bird_down = 0. After release, the first bird_down arrives exactly GRAV_DIV ticks later.
- 12 pipe_passed pulses → score 1/2. Preload to 98 and pulse 3 times → the score goes 99, 99, 99 (saturates).
- collide and pipe_passed in the same tick at score 05 → score stays 05; state 10; game_end = 1. After DIE_TICKS = 20 ticks → state 11.
- In OVER, hold start high for 5 ticks → exactly one bird_clr pulse; state 00; no second transition until start is released and pressed again.
- Assert clr_n low asynchronously mid-DYING → immediate state 00; game_end = 0; score 00 with no clock edge required.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird game sequencer.
// Contents:
//   game_state_t     - 2-bit FSM state encoding
//   bcd_t            - one BCD digit
//   *_DEFAULT        - default game constants
//   bcd_tens/bcd_ones - split a 0..99 value into BCD digits
package flappy_pkg;

    typedef enum logic [1:0] {
        READY   = 2'b00,
        PLAYING = 2'b01,
        DYING   = 2'b10,
        OVER    = 2'b11
    } game_state_t;

    typedef logic [3:0] bcd_t;

    localparam int GRAV_DIV_DEFAULT  = 2;
    localparam int DIE_TICKS_DEFAULT = 20;
    localparam int SCORE_MAX_DEFAULT = 99;

    function automatic bcd_t bcd_tens(input int value);
        return bcd_t'((value / 10) % 10);
    endfunction

    function automatic bcd_t bcd_ones(input int value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter with saturation.
// Ports:
//   clk10     in  game tick clock
//   clr_n     in  asynchronous active-low reset
//   clear     in  synchronous clear to 00 (priority over inc)
//   inc       in  add one to the score unless already at the maximum
//   max_tens  in  saturation value, tens digit
//   max_ones  in  saturation value, ones digit
//   tens      out registered tens digit
//   ones      out registered ones digit
module bcd_score_counter
    import flappy_pkg::*;
(
    input  logic clk10,
    input  logic clr_n,
    input  logic clear,
    input  logic inc,
    input  bcd_t max_tens,
    input  bcd_t max_ones,
    output bcd_t tens,
    output bcd_t ones
);

    bcd_t tens_r;
    bcd_t ones_r;
    logic at_max_s;

    // Packed BCD digits compare in the same order as their decimal values.
    assign at_max_s = ({tens_r, ones_r} >= {max_tens, max_ones});

    // Score register: clear, saturating increment with ones-to-tens carry.
    always_ff @(posedge clk10 or negedge clr_n) begin
        if (!clr_n) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (clear) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (inc && !at_max_s) begin
            if (ones_r == 4'd9) begin
                ones_r <= 4'd0;
                tens_r <= tens_r + 4'd1;
            end else begin
                ones_r <= ones_r + 4'd1;
            end
        end else begin
            tens_r <= tens_r;
            ones_r <= ones_r;
        end
    end

    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: rtl/flappy_game_ctrl_chk.sv
// Property checker for the game sequencer outputs.
// Ports (all inputs):
//   clk10, clr_n       clock and reset of the checked block
//   bird_up, bird_down movement commands, mutually exclusive
//   tens, ones         score digits, must be valid BCD (0..9)
module flappy_game_ctrl_chk
    import flappy_pkg::*;
(
    input logic clk10,
    input logic clr_n,
    input logic bird_up,
    input logic bird_down,
    input bcd_t tens,
    input bcd_t ones
);

    a_tens_bcd: assert property (@(posedge clk10) disable iff (!clr_n) (tens <= 4'd9));
    a_ones_bcd: assert property (@(posedge clk10) disable iff (!clr_n) (ones <= 4'd9));
    a_move_excl: assert property (@(posedge clk10) disable iff (!clr_n) !(bird_up && bird_down));

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer, clocked by the 10 Hz game tick.
// Decides flap/gravity moves, freezes on collision, runs the death delay,
// holds game-over, keeps the BCD score and pulses the bird recentre.
// Ports:
//   clk10        in  game tick clock
//   clr_n        in  asynchronous active-low reset
//   start        in  start/restart button level (synchronised)
//   flap         in  flap button level (synchronised)
//   collide      in  collision level
//   pipe_passed  in  one-tick pulse per cleared pipe pair
//   bird_up      out move bird up this tick
//   bird_down    out move bird down this tick
//   bird_clr     out one-tick recentre pulse
//   game_end     out high in DYING and OVER
//   state        out current state encoding
//   score_tens   out BCD tens digit
//   score_ones   out BCD ones digit
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int GRAV_DIV  = GRAV_DIV_DEFAULT,
    parameter int DIE_TICKS = DIE_TICKS_DEFAULT,
    parameter int SCORE_MAX = SCORE_MAX_DEFAULT
) (
    input  logic       clk10,
    input  logic       clr_n,
    input  logic       start,
    input  logic       flap,
    input  logic       collide,
    input  logic       pipe_passed,
    output logic       bird_up,
    output logic       bird_down,
    output logic       bird_clr,
    output logic       game_end,
    output logic [1:0] state,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones
);

    localparam logic [3:0] GRAV_LAST = 4'(GRAV_DIV - 1);
    localparam logic [7:0] DIE_LAST  = 8'(DIE_TICKS - 1);
    localparam bcd_t       MAX_TENS  = bcd_tens(SCORE_MAX);
    localparam bcd_t       MAX_ONES  = bcd_ones(SCORE_MAX);

    game_state_t state_r;
    logic        start_q_r;
    logic [3:0]  grav_cnt_r;
    logic [7:0]  die_cnt_r;
    logic        bird_up_r;
    logic        bird_down_r;
    logic        bird_clr_r;
    logic        game_end_r;
    logic        start_rise_s;
    logic        score_clear_s;
    logic        score_inc_s;

    assign start_rise_s  = start & ~start_q_r;
    assign score_clear_s = (state_r == READY) && start_rise_s;
    // A collision in the same tick suppresses the pipe credit.
    assign score_inc_s   = (state_r == PLAYING) && !collide && pipe_passed;

    // Game FSM with gravity/death counters and registered move/status outputs.
    always_ff @(posedge clk10 or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= READY;
            start_q_r   <= 1'b0;
            grav_cnt_r  <= 4'd0;
            die_cnt_r   <= 8'd0;
            bird_up_r   <= 1'b0;
            bird_down_r <= 1'b0;
            bird_clr_r  <= 1'b0;
            game_end_r  <= 1'b0;
        end else begin
            start_q_r   <= start;
            bird_up_r   <= 1'b0;
            bird_down_r <= 1'b0;
            bird_clr_r  <= 1'b0;
            case (state_r)
                READY: begin
                    game_end_r <= 1'b0;
                    if (start_rise_s) begin
                        state_r    <= PLAYING;
                        grav_cnt_r <= 4'd0;
                    end
                end
                PLAYING: begin
                    if (collide) begin
                        state_r    <= DYING;
                        game_end_r <= 1'b1;
                        die_cnt_r  <= 8'd0;
                    end else if (flap) begin
                        bird_up_r  <= 1'b1;
                        grav_cnt_r <= 4'd0;
                    end else if (grav_cnt_r == GRAV_LAST) begin
                        bird_down_r <= 1'b1;
                        grav_cnt_r  <= 4'd0;
                    end else begin
                        grav_cnt_r <= grav_cnt_r + 4'd1;
                    end
                end
                DYING: begin
                    game_end_r <= 1'b1;
                    if (die_cnt_r == DIE_LAST) begin
                        state_r <= OVER;
                    end else begin
                        die_cnt_r <= die_cnt_r + 8'd1;
                    end
                end
                OVER: begin
                    if (start_rise_s) begin
                        state_r    <= READY;
                        bird_clr_r <= 1'b1;
                        die_cnt_r  <= 8'd0;
                        game_end_r <= 1'b0;
                    end else begin
                        game_end_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= READY;
                    game_end_r <= 1'b0;
                end
            endcase
        end
    end

    bcd_score_counter u_score (
        .clk10    (clk10),
        .clr_n    (clr_n),
        .clear    (score_clear_s),
        .inc      (score_inc_s),
        .max_tens (MAX_TENS),
        .max_ones (MAX_ONES),
        .tens     (score_tens),
        .ones     (score_ones)
    );

    flappy_game_ctrl_chk u_chk (
        .clk10     (clk10),
        .clr_n     (clr_n),
        .bird_up   (bird_up_r),
        .bird_down (bird_down_r),
        .tens      (score_tens),
        .ones      (score_ones)
    );

    assign bird_up   = bird_up_r;
    assign bird_down = bird_down_r;
    assign bird_clr  = bird_clr_r;
    assign game_end  = game_end_r;
    assign state     = state_r;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: a driver applies stimulus on the
// falling edge and pushes the reference model's expected outputs; a monitor
// pops and compares just after each rising edge.
module tb_flappy_game_ctrl;

    localparam int G   = 2;
    localparam int DT  = 20;
    localparam int SMX = 99;

    logic       clk10 = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic       flap = 1'b0;
    logic       collide = 1'b0;
    logic       pipe_passed = 1'b0;
    logic       bird_up, bird_down, bird_clr, game_end;
    logic [1:0] state;
    logic [3:0] score_tens, score_ones;

    flappy_game_ctrl #(.GRAV_DIV(G), .DIE_TICKS(DT), .SCORE_MAX(SMX)) dut (
        .clk10       (clk10),
        .clr_n       (clr_n),
        .start       (start),
        .flap        (flap),
        .collide     (collide),
        .pipe_passed (pipe_passed),
        .bird_up     (bird_up),
        .bird_down   (bird_down),
        .bird_clr    (bird_clr),
        .game_end    (game_end),
        .state       (state),
        .score_tens  (score_tens),
        .score_ones  (score_ones)
    );

    always #5 clk10 = ~clk10;

    typedef struct {
        int up;
        int down;
        int clr;
        int gend;
        int st;
        int score;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 ready, 1 playing, 2 dying, 3 over.
    int m_phase = 0;
    int m_score = 0;
    int m_run = 0;      // consecutive non-flap playing ticks since last flap/start
    int m_dying = 0;    // ticks spent dying
    int m_prev_s = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_run = 0; m_dying = 0; m_prev_s = 0;
    endtask

    task automatic model_step(input int s, input int f, input int c, input int p, output exp_t e);
        int rise;
        rise = (s != 0 && m_prev_s == 0) ? 1 : 0;
        m_prev_s = s;
        e.up = 0; e.down = 0; e.clr = 0;
        if (m_phase == 0) begin
            if (rise != 0) begin
                m_phase = 1; m_score = 0; m_run = 0;
            end
        end else if (m_phase == 1) begin
            if (c != 0) begin
                m_phase = 2; m_dying = 0;
            end else begin
                if (f != 0) begin
                    e.up = 1; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run % G == 0) e.down = 1;
                end
                if (p != 0) m_score = (m_score + 1 > SMX) ? SMX : m_score + 1;
            end
        end else if (m_phase == 2) begin
            m_dying++;
            if (m_dying == DT) m_phase = 3;
        end else begin
            if (rise != 0) begin
                e.clr = 1; m_phase = 0;
            end
        end
        e.gend = (m_phase >= 2) ? 1 : 0;
        e.st = m_phase;
        e.score = m_score;
    endtask

    task automatic tick(input logic s, input logic f, input logic c, input logic p);
        exp_t e;
        @(negedge clk10);
        start = s; flap = f; collide = c; pipe_passed = p;
        model_step(int'(s), int'(f), int'(c), int'(p), e);
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_up"}, int'(bird_up), 0);
        chk({tag, "_down"}, int'(bird_down), 0);
        chk({tag, "_clr"}, int'(bird_clr), 0);
        chk({tag, "_end"}, int'(game_end), 0);
        chk({tag, "_score"}, int'(score_tens) * 10 + int'(score_ones), 0);
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk10);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("bird_up", int'(bird_up), e.up);
                chk("bird_down", int'(bird_down), e.down);
                chk("bird_clr", int'(bird_clr), e.clr);
                chk("game_end", int'(game_end), e.gend);
                chk("state", int'(state), e.st);
                chk("score_tens", int'(score_tens), e.score / 10);
                chk("score_ones", int'(score_ones), e.score % 10);
            end
        end
    end

    // Driver: directed scenarios followed by randomized play.
    initial begin
        #2;
        check_reset_outputs("por");
        @(negedge clk10);
        clr_n = 1'b1;
        model_reset();

        // Start (held for two ticks), then pure gravity.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
        // Flap held for three ticks then released.
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        // 101 pipe passes: reaches 12, then saturates at 99.
        repeat (101) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        // Collision with simultaneous pipe, death delay, OVER.
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (DT + 3) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        // Hold start in OVER: one restart only.
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        // Score 05, then collide together with a pipe pulse.
        repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
        // Asynchronous reset in the middle of DYING.
        @(posedge clk10);
        #3;
        clr_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        start = 1'b0; flap = 1'b0; collide = 1'b0; pipe_passed = 1'b0;
        @(negedge clk10);
        @(negedge clk10);
        clr_n = 1'b1;

        // Randomized play.
        repeat (1500) begin
            tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk10);
        #2;
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
